// File: rtl/trig_pkg.sv
// Shared types, constants and the sin reference for the per-bin generator.
// Configuration (N, BINS, NS, ACC_W) lives here and is seen by every file.
package trig_pkg;

   localparam int N       = 16;
   localparam int BINS    = 24;
   localparam int NS      = 6;
   localparam int ACC_W   = 24;
   localparam int AMP     = (1 << (N - 1)) - 1;
   localparam int QUARTER = 1 << (NS - 2);

   typedef logic [NS-1:0]            phase_idx_t;
   typedef logic signed [N-1:0]      sample_t;
   typedef logic [$clog2(BINS)-1:0]  bin_t;

   // round(amp*sin(2*pi*k/2^ns)), ties away from zero
   function automatic int sin_ref(input int k, input int ns,
                                  input int amp);
      real ph;
      real r;
      ph = 6.283185307179586 * real'(k) / real'(1 << ns);
      r  = real'(amp) * $sin(ph);
      if (r >= 0.0) return $rtoi(r + 0.5);
      return -$rtoi(0.5 - r);
   endfunction

endpackage

// File: rtl/bin_phase_gen_if.sv
// Config, request and sample bundle between sequencer, generator and MAC.
// master = bin sequencer side, slave = generator side.
interface bin_phase_gen_if;
   import trig_pkg::*;

   logic             cfg_we;
   bin_t             cfg_bin;
   logic [ACC_W-1:0] cfg_step;
   logic             cfg_clr;

   logic             req_valid;
   bin_t             req_bin;
   logic             req_adv;

   logic             out_valid;
   bin_t             out_bin;
   sample_t          sin_out;
   sample_t          cos_out;
   logic             out_wrap;

   modport master (
      output cfg_we, cfg_bin, cfg_step, cfg_clr,
      output req_valid, req_bin, req_adv,
      input  out_valid, out_bin, sin_out, cos_out, out_wrap
   );

   modport slave (
      input  cfg_we, cfg_bin, cfg_step, cfg_clr,
      input  req_valid, req_bin, req_adv,
      output out_valid, out_bin, sin_out, cos_out, out_wrap
   );

endinterface

// File: rtl/trig_lut.sv
// Registered dual-read sin/cos table; TRIG_QUARTER_WAVE_EN stores only
// 0..pi/2 and rebuilds the rest by mirror/negate, else a full table.
module trig_lut
   import trig_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       zero,
   input  phase_idx_t idx,
   output sample_t    sin_q,
   output sample_t    cos_q
);

   phase_idx_t cidx;
   sample_t    sv;
   sample_t    cv;

   assign cidx = idx + NS'(QUARTER);

`ifdef TRIG_QUARTER_WAVE_EN
   localparam int AW = NS - 1;

   sample_t tbl [QUARTER+1];

   for (genvar i = 0; i <= QUARTER; i++) begin : g_tbl
      localparam int V = sin_ref(i, NS, AMP);
      assign tbl[i] = N'(V);
   end

   // bit NS-2 mirrors within the half, bit NS-1 negates
   function automatic sample_t fold(input phase_idx_t k);
      logic [AW-1:0] r;
      logic [AW-1:0] a;
      r = {1'b0, k[NS-3:0]};
      a = k[NS-2] ? AW'(QUARTER) - r : r;
      return k[NS-1] ? -tbl[a] : tbl[a];
   endfunction

   assign sv = fold(idx);
   assign cv = fold(cidx);
`else
   sample_t tbl [1<<NS];

   for (genvar i = 0; i < (1 << NS); i++) begin : g_tbl
      localparam int V = sin_ref(i, NS, AMP);
      assign tbl[i] = N'(V);
   end

   assign sv = tbl[idx];
   assign cv = tbl[cidx];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sin_q <= '0;
         cos_q <= '0;
      end else if (en) begin
         sin_q <= zero ? '0 : sv;
         cos_q <= zero ? '0 : cv;
      end
   end

endmodule

// File: rtl/bin_phase_gen.sv
// Per-bin phase accumulators feeding a registered sin/cos table, 2-cycle
// latency. Optional macro TRIG_QUARTER_WAVE_EN selects quarter-wave table.
module bin_phase_gen
   import trig_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   bin_phase_gen_if.slave bus
);

   logic [ACC_W-1:0] acc  [BINS];
   logic [ACC_W-1:0] step [BINS];

   logic           bin_ok;
   logic           adv;
   bin_t           ri;
   logic [ACC_W:0] sum;

   logic       s1_valid;
   logic       s1_wrap;
   logic       s1_zero;
   bin_t       s1_bin;
   phase_idx_t s1_idx;

   logic    o_valid;
   logic    o_wrap;
   bin_t    o_bin;
   sample_t o_sin;
   sample_t o_cos;

   assign bin_ok = int'(bus.req_bin) < BINS;
   assign ri     = bin_ok ? bus.req_bin : '0;
   assign adv    = bus.req_valid && bin_ok && bus.req_adv;
   assign sum    = {1'b0, acc[ri]} + {1'b0, step[ri]};

   // sample uses the old phase; a clearing cfg write beats the advance
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BINS; i++) begin
            acc[i]  <= '0;
            step[i] <= '0;
         end
      end else begin
         for (int i = 0; i < BINS; i++) begin
            if (bus.cfg_we && bus.cfg_bin == bin_t'(i)) begin
               step[i] <= bus.cfg_step;
               if (bus.cfg_clr)
                  acc[i] <= '0;
               else if (adv && ri == bin_t'(i))
                  acc[i] <= sum[ACC_W-1:0];
            end else if (adv && ri == bin_t'(i)) begin
               acc[i] <= sum[ACC_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_bin   <= '0;
         s1_idx   <= '0;
         s1_wrap  <= 1'b0;
         s1_zero  <= 1'b0;
      end else begin
         s1_valid <= bus.req_valid;
         if (bus.req_valid) begin
            s1_bin  <= bus.req_bin;
            s1_idx  <= acc[ri][ACC_W-1 -: NS];
            s1_wrap <= adv & sum[ACC_W];
            s1_zero <= !bin_ok;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid <= 1'b0;
         o_bin   <= '0;
         o_wrap  <= 1'b0;
      end else begin
         o_valid <= s1_valid;
         if (s1_valid) begin
            o_bin  <= s1_bin;
            o_wrap <= s1_wrap;
         end
      end
   end

   trig_lut u_lut (
      .clk   (clk),
      .rst   (rst),
      .en    (s1_valid),
      .zero  (s1_zero),
      .idx   (s1_idx),
      .sin_q (o_sin),
      .cos_q (o_cos)
   );

   assign bus.out_valid = o_valid;
   assign bus.out_bin   = o_bin;
   assign bus.out_wrap  = o_wrap;
   assign bus.sin_out   = o_sin;
   assign bus.cos_out   = o_cos;

endmodule

// File: doc/bin_phase_gen.md
Name: bin_phase_gen

Overview:
- Per-bin sinusoid reference generator, the parametrised successor to the fixed-modulus per-bin table counters and full sin/cos tables.
- Each bin owns a phase accumulator with a runtime-programmable step word, so bin frequencies are no longer hard-coded moduli.
- On request, returns the bin's sin/cos sample pair and advances that bin's phase.
- Sits between the bin sequencer and the per-bin multiply/accumulate stage.

Parameters:
N, 16, sample width (signed two's complement); amplitude AMP = 2^(N-1)-1
BINS, 24, number of bins/accumulators
NS, 6, phase-index width; table resolution 2^NS points per cycle (NS >= 3)
ACC_W, 24, accumulator/step width (ACC_W > NS)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
cfg_we  in  1  write step word for cfg_bin
cfg_bin  in  $clog2(BINS)  bin being configured
cfg_step  in  ACC_W  phase increment per advance
cfg_clr  in  1  with cfg_we: also zero that bin's accumulator
req_valid  in  1  sample request
req_bin  in  $clog2(BINS)  requested bin
req_adv  in  1  advance the bin's phase after sampling
out_valid  out  1  sample pair valid
out_bin  out  $clog2(BINS)  bin of the current output
sin_out  out  N  sine sample
cos_out  out  N  cosine sample
out_wrap  out  1  the advance for this sample carried out of ACC_W (cycle completed)

Behaviour:
- Reset: all accumulators and step words = 0; out_valid = 0; out_bin, sin_out, cos_out, out_wrap = 0.
- Reset asserted mid-pipeline flushes in-flight requests; out_valid = 0 on the cycle after rst is seen.
- Phase index k = acc[bin][ACC_W-1 -: NS].
- sin value = round(AMP*sin(2πk/2^NS)), rounded half away from zero.
- cos value = sin value at index (k + 2^(NS-2)) mod 2^NS.
- Latency is fixed at 2 cycles; one request is accepted per cycle; there is no backpressure.
  - Stage 1 registers the bin, phase index and wrap.
  - Stage 2 registers the table outputs.
  - out_valid is req_valid delayed by 2 cycles.
- The sample uses the phase before the advance.
- When req_adv = 1: acc[bin] <= acc[bin] + step[bin], mod 2^ACC_W (natural wrap).
  - out_wrap = carry of that addition.
  - When req_adv = 0, out_wrap = 0.
- Request and cfg write to the same bin in the same cycle:
  - The request uses the old step and old accumulator.
  - Then cfg_clr applies and takes priority over the advance: acc = 0.
  - The new step applies from the next request.
- Writes and requests to different bins proceed independently.
- Bin index >= BINS: a request yields out_valid with sin_out = cos_out = 0, and no state changes; a cfg write is ignored.
- Step = 0 freezes phase and out_wrap stays 0.
- Step = 2^(ACC_W-1) alternates between index 0 and index 2^(NS-1).

Optional Feature:
- Macro TRIG_QUARTER_WAVE_EN.
- Defined: the table stores 2^(NS-2)+1 entries (0..π/2), and sin/cos are derived by mirror and negate on the top two index bits.
- Undefined: full 2^NS-entry sin table, and cos is read via the offset index.
- Outputs are bit-identical in both builds; the bench runs both.

Decomposition:
- Shared package trig_pkg holds:
  - the phase_idx_t, sample_t and bin_t typedefs
  - the AMP and QUARTER = 2^(NS-2) constants
  - the sin_ref() function used by the table initialisers and the bench model.
- Sub-module trig_lut is natural: a dual-read registered sin/cos table that encapsulates the TRIG_QUARTER_WAVE_EN choice.

Test Plan:
- Defaults; after reset, bin 0 step = 0x040000; 4 requests with adv=1 -> samples 2 cycles later with indices 0,1,2,3; first pair is sin=0, cos=32767.
- Continue to the 16th request -> index 16: sin=32767, cos=0. Index 32: sin=0, cos=-32767. The 64th advance -> out_wrap=1, and the next sample has index 0.
- Bin 5 step = 0x800000 -> indices alternate 0, 32; out_wrap=1 on every second advance. Bin 0 phase is unaffected when interleaved.
- Same-cycle request and cfg_we+cfg_clr on bin 3 (step 0x040000 -> 0x080000) -> that sample uses the old phase; the next sample has index 0, and the one after has index 2.
- rst asserted while 2 requests are in flight -> out_valid=0 the following cycle and stays 0 until new requests; the accumulator restarts at index 0.
- req_bin=24 -> out_valid=1 with sin=cos=0; all accumulators are unchanged (verified by resampling with adv=0).
